// File: rtl/nas_vid_pkg.sv
// Shared definitions for the video RAM arbiter: access state encoding,
// access length and the address/data widths of the 1Kx8 video RAM.
package nas_vid_pkg;

  localparam int ADDR_W = 10;  // 1K video RAM
  localparam int DATA_W = 8;   // character code width
  localparam int STAGES = 2;   // cycles per RAM access (x1, x2)

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VID1 = 3'd1,
    ST_VID2 = 3'd2,
    ST_CPU1 = 3'd3,
    ST_CPU2 = 3'd4
  } vram_state_e;

endpackage

// File: rtl/nas_vram_arb.sv
// nas_vram_arb: arbitrates a single 1Kx8 static video RAM between the
// character refresh fetch and Z80 CPU accesses. Every RAM access takes
// two cycles. CPU_PRIO=0 gives video priority and holds the CPU in WAIT;
// CPU_PRIO=1 serves the CPU at once and flags a displaced fetch as snow.
//
// Ports
//   clk, rst_n               system clock, synchronous active-low reset
//   vid_req, vid_a, blank    refresh fetch request pulse, address, blanking
//   vid_q, vid_valid         fetched character code and its update pulse
//   vid_snow                 pulse when a fetch was displaced (CPU_PRIO=1)
//   cpu_req, cpu_wr, cpu_a,  CPU level request, direction, offset and
//   cpu_wdata                write data (latched on the request rising edge)
//   cpu_rdata, cpu_ack       read data and completion pulse
//   cpu_wait_n               Z80 WAIT, low while an accepted access is pending
//   ram_*                    static RAM port (active-low strobes)
//   ovr                      sticky refresh overrun flag
module nas_vram_arb
  import nas_vid_pkg::*;
#(
  parameter int CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_a,
  input  logic              blank,
  output logic [DATA_W-1:0] vid_q,
  output logic              vid_valid,
  output logic              vid_snow,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic              ovr
);

  vram_state_e       state, state_nxt;
  logic              vid_pend, cpu_pend;
  logic              cpu_req_p0;
  logic              vid_new, cpu_rise, drop_vid;
  logic [ADDR_W-1:0] vid_a_lat, cpu_a_lat;
  logic [DATA_W-1:0] cpu_wdata_lat;
  logic              cpu_wr_lat;
  logic              nxt_vid, nxt_cpu;

  // Request qualification: blanked refresh requests are ignored outright.
  assign vid_new  = vid_req & ~blank;
  assign cpu_rise = cpu_req & ~cpu_req_p0;

  assign nxt_vid  = (state_nxt == ST_VID1) || (state_nxt == ST_VID2);
  assign nxt_cpu  = (state_nxt == ST_CPU1) || (state_nxt == ST_CPU2);

  // Write data only changes at acceptance, so it is stable across x1 and x2.
  assign ram_wdata = cpu_wdata_lat;

  always_comb begin
    state_nxt = state;
    drop_vid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CPU_PRIO == 0) begin
          // A refresh request seen this cycle must not be overtaken by the CPU.
          if (vid_pend)
            state_nxt = ST_VID1;
          else if (cpu_pend && !vid_new)
            state_nxt = ST_CPU1;
        end else begin
          if (cpu_pend) begin
            state_nxt = ST_CPU1;
            drop_vid  = vid_pend;
          end else if (vid_pend) begin
            state_nxt = ST_VID1;
          end
        end
      end
      ST_VID1: begin
        // CPU priority: a fetch still in x1 is abandoned so WAIT stays short.
        if ((CPU_PRIO != 0) && cpu_pend) begin
          state_nxt = ST_CPU1;
          drop_vid  = 1'b1;
        end else begin
          state_nxt = ST_VID2;
        end
      end
      ST_VID2: state_nxt = ST_IDLE;
      ST_CPU1: state_nxt = ST_CPU2;
      // Chain straight into a waiting fetch to keep refresh latency bounded.
      ST_CPU2: state_nxt = vid_pend ? ST_VID1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: request latches (data only, not reset)
  always_ff @(posedge clk) begin
    if (vid_new)
      vid_a_lat <= vid_a;
    if (cpu_rise) begin
      cpu_wr_lat    <= cpu_wr;
      cpu_a_lat     <= cpu_a;
      cpu_wdata_lat <= cpu_wdata;
    end
  end

  // Stage p1: arbitration state, strobes and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vid_pend   <= 1'b0;
      cpu_pend   <= 1'b0;
      cpu_req_p0 <= 1'b0;
      vid_q      <= '0;
      cpu_rdata  <= '0;
      ram_a      <= '0;
      vid_valid  <= 1'b0;
      vid_snow   <= 1'b0;
      cpu_ack    <= 1'b0;
      ovr        <= 1'b0;
      cpu_wait_n <= 1'b1;
      ram_ce_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
    end else begin
      state      <= state_nxt;
      cpu_req_p0 <= cpu_req;

      // Completion or displacement clears the fetch; a late re-request is lost.
      if ((state == ST_VID2) || drop_vid)
        vid_pend <= 1'b0;
      else if (vid_new)
        vid_pend <= 1'b1;

      if (vid_new && vid_pend)
        ovr <= 1'b1;

      if (cpu_rise)
        cpu_pend <= 1'b1;
      else if (state == ST_CPU2)
        cpu_pend <= 1'b0;

      // Low from the cycle after acceptance up to the cycle before the ack.
      cpu_wait_n <= !(cpu_pend && (state != ST_CPU2));

      vid_valid <= (state == ST_VID2);
      vid_snow  <= drop_vid;
      cpu_ack   <= (state == ST_CPU2);

      if (state == ST_VID2)
        vid_q <= ram_rdata;
      if ((state == ST_CPU2) && !cpu_wr_lat)
        cpu_rdata <= ram_rdata;

      // Strobes are registered from the next state so they line up with it.
      ram_ce_n <= !(nxt_vid || nxt_cpu);
      ram_oe_n <= !(nxt_vid || (nxt_cpu && !cpu_wr_lat));
      ram_we_n <= !((state_nxt == ST_CPU2) && cpu_wr_lat);

      // Address is loaded on entry to x1 and otherwise held.
      if ((state_nxt == ST_VID1) && (state != ST_VID1))
        ram_a <= vid_new ? vid_a : vid_a_lat;
      else if ((state_nxt == ST_CPU1) && (state != ST_CPU1))
        ram_a <= cpu_a_lat;
    end
  end

endmodule
